alu_arbiter: RTL

Two-requester scheduler that shares one `alu_32` (AND/OR/XOR/NOR/SLT/ADD/SUB/MOD) between independent clients. It accepts one operation at a time over a valid/ready handshake, arbitrates round-robin, and drives and holds the ALU operands for the operation's latency. For the multi-cycle MOD it also issues the ALU's clear pulse. It then returns the captured result to the originating requester over a response handshake.

---
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one multi-cycle ALU between two requesters.
// One operation is in flight at a time; its result is returned on the owner's response channel.
//
// Handshake: a request transfers on a rising edge where req_valid_k and req_ready_k are both high;
// a response transfers on a rising edge where rsp_valid_k and rsp_ready_k are both high.
module alu_arbiter #(
    parameter int MOD_LATENCY = 34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_1,
    input  logic [2:0]  req_op_0,
    input  logic [2:0]  req_op_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_reset,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int CW = (MOD_LATENCY > 1) ? $clog2(MOD_LATENCY) : 1;
    localparam logic [2:0] OP_MOD = 3'b111;

    typedef enum logic [1:0] {IDLE, CLR, EXEC, RESP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          gid_q, gid_d;
    logic [31:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]    op_q, op_d;

    logic          grant;
    logic          accept;
    logic          rsp_fire;
    logic [2:0]    grant_op;

    // On a tie the requester that was not served last wins; a lone requester always wins.
    assign grant    = (req_valid_0 & req_valid_1) ? ~last_q : req_valid_1;
    assign accept   = (state_q == IDLE) & reset & (req_valid_0 | req_valid_1);
    assign grant_op = grant ? req_op_1 : req_op_0;
    assign rsp_fire = (state_q == RESP) & (gid_q ? rsp_ready_1 : rsp_ready_0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (grant_op == OP_MOD) ? CLR : EXEC;
            CLR:  state_d = EXEC;
            EXEC: if (cnt_q == '0) state_d = RESP;
            RESP: if (rsp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        gid_d  = gid_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        res_d  = res_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_d = grant;
                    gid_d  = grant;
                    a_d    = grant ? req_a_1 : req_a_0;
                    b_d    = grant ? req_b_1 : req_b_0;
                    op_d   = grant_op;
                    cnt_d  = '0;
                end
            end
            // The down-counter only runs for MOD; single-cycle ops enter EXEC with it at zero.
            CLR:  cnt_d = CW'(MOD_LATENCY - 1);
            EXEC: begin
                if (cnt_q == '0) begin
                    res_d = alu_result;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            last_q <= 1'b1;
            gid_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            res_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
            gid_q  <= gid_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            res_q  <= res_d;
        end
    end

    // The ALU is held in reset together with the controller, and pulsed once ahead of a MOD.
    always_comb begin
        req_ready_0 = accept & ~grant;
        req_ready_1 = accept & grant;
        rsp_valid_0 = (state_q == RESP) & ~gid_q;
        rsp_valid_1 = (state_q == RESP) & gid_q;
        rsp_data    = res_q;
        alu_a       = a_q;
        alu_b       = b_q;
        alu_op      = op_q;
        alu_reset   = ~reset | (state_q == CLR);
        busy        = (state_q != IDLE);
        dbg_state   = state_q;
    end

endmodule
